// File: rtl/alu_mul_seq_if.sv
// Request/result and ALU-drive bundle for the shift-add multiply sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request that is only honoured in IDLE.
interface alu_mul_seq_if #(
  parameter int WIDTH = 64
);
  // request side
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // result side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             carry;
  // ALU drive
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_fs;
  logic             alu_c0;
  // ALU return, {v,c,n,z}
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_status;

  // Requester plus ALU side: issues operands, returns ALU results.
  modport master (
    output start, op_a, op_b, alu_out, alu_status,
    input  busy, done, product, carry, alu_a, alu_b, alu_fs, alu_c0
  );

  // Sequencer side.
  modport slave (
    input  start, op_a, op_b, alu_out, alu_status,
    output busy, done, product, carry, alu_a, alu_b, alu_fs, alu_c0
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier borrowing the shared 64-bit ALU, one ALU op per cycle.
// Latency: 1 + 3 per set bit + 2 per clear bit of op_b up to its highest set bit (1..193 cycles).
// Backpressure: busy high outside IDLE; start while busy is dropped, product held until next start.
module alu_mul_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_mul_seq_if.slave   bus
);

  // ALU function-select encodings used by this sequencer
  localparam logic [4:0] FS_NOP = 5'b00000;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [4:0] FS_SHR = 5'b10100;

  // ALU status bit positions, {v,c,n,z}
  localparam int ST_C = 2;
  localparam int ST_Z = 0;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] m_reg;     // multiplicand, shifted left each bit
  logic [WIDTH-1:0] q_reg;     // multiplier, shifted right each bit
  logic [WIDTH-1:0] p_reg;     // partial product
  logic [CNT_W-1:0] cnt;       // index of the multiplier bit being processed
  logic [WIDTH-1:0] product_reg;
  logic             carry_reg;

  logic             accept;
  logic             last_shift;

  // A request is taken only from IDLE; anything else is ignored.
  assign accept = (state == S_IDLE) && bus.start;

  // Stop shifting once the multiplier has run out of set bits, or all bits are spent.
  assign last_shift = bus.alu_status[ST_Z] || (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: ADD only for set multiplier bits, every bit gets SHL then SHR.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op_b == '0) begin
            state_nxt = S_DONE;
          end else if (bus.op_b[0]) begin
            state_nxt = S_ADD;
          end else begin
            state_nxt = S_SHL;
          end
        end
      end
      S_ADD:  state_nxt = S_SHL;
      S_SHL:  state_nxt = S_SHR;
      S_SHR: begin
        if (last_shift) begin
          state_nxt = S_DONE;
        end else if (bus.alu_out[0]) begin
          state_nxt = S_ADD;
        end else begin
          state_nxt = S_SHL;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: ALU operands/function from state and working registers, plus status flags.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_fs = FS_NOP;
    bus.alu_c0 = 1'b0;
    bus.busy   = (state != S_IDLE);
    bus.done   = (state == S_DONE);
    case (state)
      S_ADD: begin
        bus.alu_a  = p_reg;
        bus.alu_b  = m_reg;
        bus.alu_fs = FS_ADD;
      end
      S_SHL: begin
        bus.alu_a  = m_reg;
        bus.alu_b  = WIDTH'(1);
        bus.alu_fs = FS_SHL;
      end
      S_SHR: begin
        bus.alu_a  = q_reg;
        bus.alu_b  = WIDTH'(1);
        bus.alu_fs = FS_SHR;
      end
      default: begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_fs = FS_NOP;
      end
    endcase
  end

  // Working registers: capture operands on accept, then write back the ALU result of each op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg     <= '0;
      q_reg     <= '0;
      p_reg     <= '0;
      cnt       <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            m_reg     <= bus.op_a;
            q_reg     <= bus.op_b;
            p_reg     <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
          end
        end
        S_ADD: begin
          p_reg     <= bus.alu_out;
          // sticky: any wrap of the partial product is reported
          carry_reg <= carry_reg | bus.alu_status[ST_C];
        end
        S_SHL: begin
          m_reg <= bus.alu_out;
        end
        S_SHR: begin
          q_reg <= bus.alu_out;
          if (!last_shift) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          m_reg <= m_reg;
        end
      endcase
    end
  end

  // Result register: loaded on the edge entering DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg <= '0;
    end else if (state_nxt == S_DONE && state != S_DONE) begin
      // a zero multiplier goes straight from IDLE, where p_reg still holds the old result
      product_reg <= (state == S_IDLE) ? '0 : p_reg;
    end
  end

  assign bus.product = product_reg;
  assign bus.carry   = carry_reg;

endmodule
